// File: rtl/nrf_spi_cmd_ctrl.sv
// nrf_spi_cmd_ctrl: sequences one nRF24L01 command (cmd byte + data bytes) through a byte-level SPI engine,
// owning chip select and splitting returned bytes into STATUS and read data.
module nrf_spi_cmd_ctrl #(
   parameter int         MAX_BYTES     = 32,
   parameter int         LEN_W         = 6,
   parameter int         CS_SETUP_CLKS = 2,
   parameter int         CS_HOLD_CLKS  = 2,
   parameter int         CS_IDLE_CLKS  = 4,
   parameter logic [7:0] DUMMY_BYTE    = 8'hFF
) (
   input  logic             i_Clk,
   input  logic             i_Rst_L,
   input  logic             i_Cmd_Valid,
   output logic             o_Cmd_Ready,
   input  logic [7:0]       i_Cmd_Byte,
   input  logic [LEN_W-1:0] i_Cmd_Len,
   input  logic             i_Cmd_Rd,
   input  logic [7:0]       i_Wr_Byte,
   input  logic             i_Wr_Valid,
   output logic             o_Wr_Ready,
   output logic [7:0]       o_Rd_Byte,
   output logic             o_Rd_Valid,
   output logic [7:0]       o_Status,
   output logic             o_Done,
   output logic [7:0]       o_TX_Byte,
   output logic             o_TX_DV,
   input  logic             i_TX_Ready,
   input  logic             i_RX_DV,
   input  logic [7:0]       i_RX_Byte,
   output logic             o_SPI_CS_n
);
   typedef enum logic [2:0] {IDLE, CS_SETUP, SEND, WAIT_RX, CS_HOLD, CS_IDLE} state_t;
   state_t           state_q, state_d;
   logic [7:0]       cmd_q, cmd_d, cnt_q, cnt_d, tx_byte_q, tx_byte_d, rd_byte_q, rd_byte_d, status_q, status_d;
   logic [LEN_W-1:0] len_q, len_d, idx_q, idx_d;
   logic             rd_q, rd_d, cs_n_q, cs_n_d, rdy_q, rdy_d, tx_dv_q, tx_dv_d;
   logic             wr_rdy_q, wr_rdy_d, rd_valid_q, rd_valid_d, done_q, done_d;
   logic             data_ph, can_issue;

   assign data_ph   = idx_q != '0;
   // write-data bytes additionally need the producer to have a byte ready
   assign can_issue = i_TX_Ready && (!data_ph || rd_q || i_Wr_Valid);

   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      cnt_d      = cnt_q;
      tx_byte_d  = tx_byte_q;
      rd_byte_d  = rd_byte_q;
      status_d   = status_q;
      len_d      = len_q;
      idx_d      = idx_q;
      rd_d       = rd_q;
      cs_n_d     = cs_n_q;
      tx_dv_d    = 1'b0;
      wr_rdy_d   = 1'b0;
      rd_valid_d = 1'b0;
      done_d     = 1'b0;
      case (state_q)
         IDLE: if (i_Cmd_Valid && rdy_q) begin
            cmd_d   = i_Cmd_Byte;
            rd_d    = i_Cmd_Rd;
            len_d   = (i_Cmd_Len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : i_Cmd_Len;
            idx_d   = '0;
            cnt_d   = '0;
            cs_n_d  = 1'b0;
            state_d = CS_SETUP;
         end
         CS_SETUP: if (cnt_q == 8'(CS_SETUP_CLKS - 1)) begin
            cnt_d   = '0;
            state_d = SEND;
         end else cnt_d = cnt_q + 8'd1;
         SEND: if (can_issue) begin
            tx_dv_d   = 1'b1;
            tx_byte_d = !data_ph ? cmd_q : rd_q ? DUMMY_BYTE : i_Wr_Byte;
            wr_rdy_d  = data_ph && !rd_q;
            state_d   = WAIT_RX;
         end
         WAIT_RX: if (i_RX_DV) begin
            if (!data_ph) status_d = i_RX_Byte;
            else if (rd_q) begin
               rd_byte_d  = i_RX_Byte;
               rd_valid_d = 1'b1;
            end
            if (idx_q == len_q) begin
               cnt_d   = '0;
               state_d = CS_HOLD;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = SEND;
            end
         end
         CS_HOLD: if (cnt_q == 8'(CS_HOLD_CLKS - 1)) begin
            cnt_d   = '0;
            cs_n_d  = 1'b1;
            done_d  = 1'b1;
            state_d = CS_IDLE;
         end else cnt_d = cnt_q + 8'd1;
         CS_IDLE: if (cnt_q == 8'(CS_IDLE_CLKS - 1)) begin
            cnt_d   = '0;
            state_d = IDLE;
         end else cnt_d = cnt_q + 8'd1;
         default: state_d = IDLE;
      endcase
      rdy_d = state_d == IDLE;
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q    <= IDLE;
         cmd_q      <= '0;
         cnt_q      <= '0;
         tx_byte_q  <= '0;
         rd_byte_q  <= '0;
         status_q   <= '0;
         len_q      <= '0;
         idx_q      <= '0;
         rd_q       <= 1'b0;
         cs_n_q     <= 1'b1;
         rdy_q      <= 1'b0;
         tx_dv_q    <= 1'b0;
         wr_rdy_q   <= 1'b0;
         rd_valid_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         cnt_q      <= cnt_d;
         tx_byte_q  <= tx_byte_d;
         rd_byte_q  <= rd_byte_d;
         status_q   <= status_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         rd_q       <= rd_d;
         cs_n_q     <= cs_n_d;
         rdy_q      <= rdy_d;
         tx_dv_q    <= tx_dv_d;
         wr_rdy_q   <= wr_rdy_d;
         rd_valid_q <= rd_valid_d;
         done_q     <= done_d;
      end
   end

   assign o_Cmd_Ready = rdy_q;
   assign o_Wr_Ready  = wr_rdy_q;
   assign o_Rd_Byte   = rd_byte_q;
   assign o_Rd_Valid  = rd_valid_q;
   assign o_Status    = status_q;
   assign o_Done      = done_q;
   assign o_TX_Byte   = tx_byte_q;
   assign o_TX_DV     = tx_dv_q;
   assign o_SPI_CS_n  = cs_n_q;
endmodule

// File: tb/tb_nrf_spi_cmd_ctrl.sv
// tb_nrf_spi_cmd_ctrl: randomized checks of nrf_spi_cmd_ctrl against a transaction-level model,
// with a behavioural SPI engine that answers each issued byte after a random delay.
module tb_nrf_spi_cmd_ctrl;
   localparam int MAXB = 32, LW = 6, SETUP = 2, HOLD = 2, IDLEC = 4;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          i_Cmd_Valid = 0, i_Cmd_Rd = 0, i_Wr_Valid = 0, i_TX_Ready = 1, i_RX_DV = 0;
   logic [7:0]    i_Cmd_Byte = 0, i_Wr_Byte = 0, i_RX_Byte = 0;
   logic [LW-1:0] i_Cmd_Len = 0;
   logic          o_Cmd_Ready, o_Wr_Ready, o_Rd_Valid, o_Done, o_TX_DV, o_SPI_CS_n;
   logic [7:0]    o_Rd_Byte, o_Status, o_TX_Byte;

   nrf_spi_cmd_ctrl dut (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_Cmd_Valid(i_Cmd_Valid), .o_Cmd_Ready(o_Cmd_Ready),
      .i_Cmd_Byte(i_Cmd_Byte), .i_Cmd_Len(i_Cmd_Len), .i_Cmd_Rd(i_Cmd_Rd),
      .i_Wr_Byte(i_Wr_Byte), .i_Wr_Valid(i_Wr_Valid), .o_Wr_Ready(o_Wr_Ready),
      .o_Rd_Byte(o_Rd_Byte), .o_Rd_Valid(o_Rd_Valid), .o_Status(o_Status), .o_Done(o_Done),
      .o_TX_Byte(o_TX_Byte), .o_TX_DV(o_TX_DV), .i_TX_Ready(i_TX_Ready), .i_RX_DV(i_RX_DV),
      .i_RX_Byte(i_RX_Byte), .o_SPI_CS_n(o_SPI_CS_n)
   );

   int tests = 0, fails = 0;
   logic [7:0] rsp_q[$], tx_log[$], rd_log[$], wr_q[$];
   int wr_idx = 0, stall_at = -1, stall_cnt = 0, n_done = 0, n_wr = 0;
   int cs_low = 0, cs_rise = 0, hi_run = 0, min_gap = 1000, n_fall = 0, dly = 0;
   bit busy = 0;
   logic cs_prev = 1'b1;

   // engine model, output monitor and write-data producer, all on the falling edge
   always @(negedge clk) begin
      if (!rst_n) begin
         busy = 0;
         i_TX_Ready = 1;
         i_RX_DV = 0;
      end else begin
         i_RX_DV = 0;
         if (o_TX_DV) begin
            tx_log.push_back(o_TX_Byte);
            busy = 1;
            i_TX_Ready = 0;
            dly = $urandom_range(1, 4);
         end else if (busy) begin
            dly--;
            if (dly == 0) begin
               busy = 0;
               i_TX_Ready = 1;
               i_RX_DV = 1;
               i_RX_Byte = rsp_q.size() > 0 ? rsp_q.pop_front() : 8'h00;
            end
         end
         if (o_Wr_Ready) begin n_wr++; wr_idx++; end
         if (o_Rd_Valid) rd_log.push_back(o_Rd_Byte);
         if (o_Done) n_done++;
      end
      if (!o_SPI_CS_n) cs_low++;
      if (o_SPI_CS_n && !cs_prev) cs_rise++;
      if (!o_SPI_CS_n && cs_prev) begin
         n_fall++;
         if (n_fall > 1 && hi_run < min_gap) min_gap = hi_run;
      end
      hi_run = o_SPI_CS_n ? hi_run + 1 : 0;
      cs_prev = o_SPI_CS_n;
      if (stall_at == wr_idx && stall_cnt < 10) begin
         i_Wr_Valid = 0;
         stall_cnt++;
      end else i_Wr_Valid = wr_idx < wr_q.size();
      i_Wr_Byte = wr_idx < wr_q.size() ? wr_q[wr_idx] : 8'h00;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic bit same(input logic [7:0] a[$], input logic [7:0] b[$]);
      if (a.size() != b.size()) return 0;
      foreach (a[i]) if (a[i] !== b[i]) return 0;
      return 1;
   endfunction

   // transaction-level model: what the MOSI byte stream and read stream must be
   function automatic void model(input logic [7:0] c, input int len, input bit rd, input logic [7:0] wr[$],
                                 input logic [7:0] rsp[$], output logic [7:0] etx[$], output logic [7:0] erd[$]);
      int n = len > MAXB ? MAXB : len;
      etx = {c};
      erd = {};
      for (int i = 1; i <= n; i++) begin
         etx.push_back(rd ? 8'hFF : wr[i-1]);
         if (rd) erd.push_back(rsp[i]);
      end
   endfunction

   task automatic clear_mon();
      tx_log.delete(); rd_log.delete(); rsp_q.delete(); wr_q.delete();
      wr_idx = 0; stall_at = -1; stall_cnt = 0; n_done = 0; n_wr = 0;
      cs_low = 0; cs_rise = 0; n_fall = 0; min_gap = 1000;
   endtask

   task automatic issue(input logic [7:0] c, input logic [LW-1:0] l, input logic r);
      int b = 0;
      tick();
      i_Cmd_Byte = c; i_Cmd_Len = l; i_Cmd_Rd = r; i_Cmd_Valid = 1;
      while (!o_Cmd_Ready && b < 100) begin tick(); b++; end
      tick();
      i_Cmd_Valid = 0;
   endtask

   task automatic wait_idle(input string name, input int n);
      int b = 0;
      while (!(n_done >= n && o_Cmd_Ready) && b < 3000) begin tick(); b++; end
      if (b >= 3000) begin
         tests++; fails++;
         $display("FAIL %s timeout: done=%0d want %0d", name, n_done, n);
      end
   endtask

   task automatic test_reset();
      rst_n = 0;
      repeat (3) tick();
      tests++; if (o_SPI_CS_n !== 1'b1) begin fails++; $display("FAIL rst cs_n: got %b want 1", o_SPI_CS_n); end
      tests++; if (o_Cmd_Ready !== 1'b0) begin fails++; $display("FAIL rst ready: got %b want 0", o_Cmd_Ready); end
      tests++; if ({o_TX_DV, o_Wr_Ready, o_Rd_Valid, o_Done} !== 4'b0) begin fails++; $display("FAIL rst pulses: got %b want 0000", {o_TX_DV, o_Wr_Ready, o_Rd_Valid, o_Done}); end
      tests++; if ({o_TX_Byte, o_Rd_Byte, o_Status} !== 24'h0) begin fails++; $display("FAIL rst bytes: got %h want 000000", {o_TX_Byte, o_Rd_Byte, o_Status}); end
      rst_n = 1;
      #1;
      tests++; if (o_Cmd_Ready !== 1'b0) begin fails++; $display("FAIL rst ready before clk: got %b want 0", o_Cmd_Ready); end
      tick();
      tests++; if (o_Cmd_Ready !== 1'b1) begin fails++; $display("FAIL rst ready after clk: got %b want 1", o_Cmd_Ready); end
   endtask

   task automatic test_nop();
      clear_mon();
      rsp_q = {8'h0E};
      issue(8'hFF, 0, 0);
      wait_idle("nop", 1);
      tests++; if (tx_log.size() != 1 || tx_log[0] !== 8'hFF) begin fails++; $display("FAIL nop tx: got %0d bytes want 1 x FF", tx_log.size()); end
      tests++; if (o_Status !== 8'h0E) begin fails++; $display("FAIL nop status: got %h want 0e", o_Status); end
      tests++; if (n_done != 1 || rd_log.size() != 0) begin fails++; $display("FAIL nop done/rd: got %0d/%0d want 1/0", n_done, rd_log.size()); end
      tests++; if (cs_low < SETUP + HOLD || cs_rise != 1) begin fails++; $display("FAIL nop cs: low %0d rises %0d want >=%0d/1", cs_low, cs_rise, SETUP + HOLD); end
   endtask

   task automatic test_read_reg();
      logic [7:0] etx[$], erd[$];
      clear_mon();
      rsp_q = {8'h0E, 8'h02};
      model(8'h05, 1, 1, wr_q, rsp_q, etx, erd);
      issue(8'h05, 1, 1);
      wait_idle("rdreg", 1);
      tests++; if (!same(tx_log, etx)) begin fails++; $display("FAIL rdreg tx: got %0d bytes want %0d", tx_log.size(), etx.size()); end
      tests++; if (!same(rd_log, erd)) begin fails++; $display("FAIL rdreg rd: got %0d bytes want 1 x 02", rd_log.size()); end
      tests++; if (o_Status !== 8'h0E || n_wr != 0) begin fails++; $display("FAIL rdreg status/wr: got %h/%0d want 0e/0", o_Status, n_wr); end
   endtask

   task automatic test_write_stall();
      logic [7:0] etx[$], erd[$], rsp[$];
      clear_mon();
      for (int i = 0; i < 6; i++) rsp.push_back(8'($urandom));
      wr_q = {8'hE7, 8'hE7, 8'hE7, 8'hE7, 8'hE7};
      rsp_q = rsp;
      stall_at = 2;
      model(8'h30, 5, 0, wr_q, rsp, etx, erd);
      issue(8'h30, 5, 0);
      wait_idle("wrstall", 1);
      tests++; if (!same(tx_log, etx)) begin fails++; $display("FAIL wrstall tx: got %0d bytes want %0d", tx_log.size(), etx.size()); end
      tests++; if (n_wr != 5 || n_done != 1) begin fails++; $display("FAIL wrstall wr/done: got %0d/%0d want 5/1", n_wr, n_done); end
      tests++; if (cs_rise != 1 || rd_log.size() != 0) begin fails++; $display("FAIL wrstall cs/rd: got %0d/%0d want 1/0", cs_rise, rd_log.size()); end
      tests++; if (o_Status !== rsp[0]) begin fails++; $display("FAIL wrstall status: got %h want %h", o_Status, rsp[0]); end
   endtask

   task automatic test_payload();
      logic [7:0] etx[$], erd[$], rsp[$];
      for (int p = 0; p < 2; p++) begin
         clear_mon();
         rsp.delete();
         for (int i = 0; i < 33; i++) rsp.push_back(8'($urandom));
         rsp_q = rsp;
         model(8'h61, p ? 40 : 32, 1, wr_q, rsp, etx, erd);
         issue(8'h61, p ? 6'd40 : 6'd32, 1);
         wait_idle("payload", 1);
         tests++; if (!same(tx_log, etx) || tx_log.size() != 33) begin fails++; $display("FAIL payload%0d tx: got %0d bytes want 33", p, tx_log.size()); end
         tests++; if (!same(rd_log, erd)) begin fails++; $display("FAIL payload%0d rd: got %0d bytes want %0d", p, rd_log.size(), erd.size()); end
         tests++; if (o_Status !== rsp[0] || n_wr != 0) begin fails++; $display("FAIL payload%0d status/wr: got %h/%0d want %h/0", p, o_Status, n_wr, rsp[0]); end
      end
   endtask

   task automatic test_reset_mid();
      int b = 0;
      clear_mon();
      issue(8'h61, 3, 1);
      while (tx_log.size() < 2 && b < 500) begin tick(); b++; end
      rst_n = 0;
      #1;
      tests++; if (o_SPI_CS_n !== 1'b1 || o_TX_DV !== 1'b0) begin fails++; $display("FAIL rstmid cs/dv: got %b/%b want 1/0", o_SPI_CS_n, o_TX_DV); end
      repeat (3) tick();
      tests++; if (n_done != 0 || tx_log.size() != 2) begin fails++; $display("FAIL rstmid done/tx: got %0d/%0d want 0/2", n_done, tx_log.size()); end
      rst_n = 1;
      tick();
      tests++; if (o_Cmd_Ready !== 1'b1) begin fails++; $display("FAIL rstmid ready: got %b want 1", o_Cmd_Ready); end
      clear_mon();
      rsp_q = {8'h4E};
      issue(8'hFF, 0, 0);
      wait_idle("rstmid nop", 1);
      tests++; if (o_Status !== 8'h4E || n_done != 1 || tx_log.size() != 1) begin fails++; $display("FAIL rstmid nop: status %h done %0d tx %0d want 4e/1/1", o_Status, n_done, tx_log.size()); end
   endtask

   task automatic test_back_to_back();
      int b = 0;
      clear_mon();
      rsp_q = {8'h0E, 8'h1E};
      tick();
      i_Cmd_Byte = 8'hFF; i_Cmd_Len = 0; i_Cmd_Rd = 0; i_Cmd_Valid = 1;
      while (n_done < 2 && b < 2000) begin tick(); b++; end
      i_Cmd_Valid = 0;
      wait_idle("b2b", 2);
      tests++; if (n_done != 2 || tx_log.size() != 2) begin fails++; $display("FAIL b2b done/tx: got %0d/%0d want 2/2", n_done, tx_log.size()); end
      tests++; if (n_fall != 2 || min_gap < IDLEC) begin fails++; $display("FAIL b2b cs gap: falls %0d gap %0d want 2/>=%0d", n_fall, min_gap, IDLEC); end
      tests++; if (o_Status !== 8'h1E) begin fails++; $display("FAIL b2b status: got %h want 1e", o_Status); end
   endtask

   task automatic test_random();
      logic [7:0] etx[$], erd[$], rsp[$], wr[$], c;
      int len, n;
      bit rd;
      for (int k = 0; k < 8; k++) begin
         clear_mon();
         rsp.delete(); wr.delete();
         c = 8'($urandom);
         len = $urandom_range(0, 40);
         rd = 1'($urandom);
         n = len > MAXB ? MAXB : len;
         for (int i = 0; i <= n; i++) rsp.push_back(8'($urandom));
         if (!rd) for (int i = 0; i < n; i++) wr.push_back(8'($urandom));
         rsp_q = rsp;
         wr_q = wr;
         model(c, len, rd, wr, rsp, etx, erd);
         issue(c, LW'(len), rd);
         wait_idle("random", 1);
         tests++; if (!same(tx_log, etx)) begin fails++; $display("FAIL rand%0d tx: got %0d bytes want %0d", k, tx_log.size(), etx.size()); end
         tests++; if (!same(rd_log, erd)) begin fails++; $display("FAIL rand%0d rd: got %0d bytes want %0d", k, rd_log.size(), erd.size()); end
         tests++; if (o_Status !== rsp[0] || n_wr != (rd ? 0 : n) || n_done != 1) begin fails++; $display("FAIL rand%0d status/wr/done: got %h/%0d/%0d want %h/%0d/1", k, o_Status, n_wr, n_done, rsp[0], rd ? 0 : n); end
      end
   endtask

   initial begin
      test_reset();
      test_nop();
      test_read_reg();
      test_write_stall();
      test_payload();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/nrf_spi_cmd_ctrl.md
Name: nrf_spi_cmd_ctrl

Overview:
Transaction sequencer for the byte-level spi_transceiver engine driving the nRF24L01 radio. Accepts one command (command byte plus 0..MAX_BYTES data bytes), owns chip select, issues bytes to the engine one at a time, and splits the returned bytes into the STATUS byte and read data. Sits between the radio driver FSM and spi_transceiver.

Parameters:
MAX_BYTES, 32, maximum data bytes after the command byte (nRF payload limit)
LEN_W, 6, width of i_Cmd_Len; must satisfy 2**LEN_W > MAX_BYTES
CS_SETUP_CLKS, 2, clocks from CS low to first o_TX_DV (1..255)
CS_HOLD_CLKS, 2, clocks from last i_RX_DV to CS high (1..255)
CS_IDLE_CLKS, 4, minimum CS-high clocks before o_Cmd_Ready reasserts (1..255)
DUMMY_BYTE, 8'hFF, byte shifted out during read data phase

Ports:
i_Clk  in  1  system clock
i_Rst_L  in  1  reset, asynchronous, active-low
i_Cmd_Valid  in  1  command request
o_Cmd_Ready  out  1  controller idle, command accepted on valid&&ready
i_Cmd_Byte  in  8  nRF command byte (first byte on MOSI)
i_Cmd_Len  in  LEN_W  number of data bytes after command
i_Cmd_Rd  in  1  1 = read (send DUMMY_BYTE, forward RX), 0 = write
i_Wr_Byte  in  8  write data stream
i_Wr_Valid  in  1  write data available
o_Wr_Ready  out  1  single-cycle pulse: i_Wr_Byte consumed
o_Rd_Byte  out  8  read data
o_Rd_Valid  out  1  single-cycle pulse per read data byte
o_Status  out  8  STATUS byte from last transaction
o_Done  out  1  single-cycle pulse at transaction end
o_TX_Byte  out  8  to engine i_TX_Byte
o_TX_DV  out  1  to engine i_TX_DV
i_TX_Ready  in  1  from engine o_TX_Ready
i_RX_DV  in  1  from engine o_RX_DV
i_RX_Byte  in  8  from engine o_RX_Byte
o_SPI_CS_n  out  1  radio chip select, active-low

Behaviour:
- Reset (async, i_Rst_L=0): state IDLE; o_SPI_CS_n=1, o_Cmd_Ready=0 during reset, 1 first clock after release; o_TX_DV, o_Wr_Ready, o_Rd_Valid, o_Done=0; o_TX_Byte, o_Rd_Byte, o_Status=8'h00; all counters 0.
- Reset mid-transaction: CS deasserts immediately (asynchronously), transaction abandoned, no o_Done, no further o_TX_DV.
- States: IDLE -> CS_SETUP -> SEND -> WAIT_RX -> (SEND | CS_HOLD) -> CS_IDLE -> IDLE.
- IDLE: o_Cmd_Ready=1. On i_Cmd_Valid: latch byte, rd flag, len = min(i_Cmd_Len, MAX_BYTES); byte index=0; CS low next clock; go CS_SETUP.
- CS_SETUP: count CS_SETUP_CLKS clocks, then SEND.
- SEND: index 0 sends command byte; index>0 sends DUMMY_BYTE (read) or i_Wr_Byte (write). Issue requires i_TX_Ready=1 and, for write data, i_Wr_Valid=1; otherwise stall with CS held low, no timeout. On issue: o_TX_DV=1 for exactly one clock, o_TX_Byte registered same clock, o_Wr_Ready pulse same clock for write data; go WAIT_RX.
- WAIT_RX: on i_RX_DV: index 0 -> o_Status<=i_RX_Byte; index>0 and read -> o_Rd_Byte<=i_RX_Byte, o_Rd_Valid pulse next clock; write-phase RX bytes discarded. If index==len go CS_HOLD else index++ and SEND.
- i_RX_DV outside WAIT_RX ignored. o_Wr_Ready never pulses in read or len=0 commands.
- CS_HOLD: CS_HOLD_CLKS clocks, then o_SPI_CS_n=1 and o_Done pulse on same clock; go CS_IDLE.
- CS_IDLE: CS_IDLE_CLKS clocks with CS high, then IDLE (o_Cmd_Ready=1). Back-to-back commands therefore always see CS-high gap >= CS_IDLE_CLKS.
- len=0: command byte only, STATUS captured, no read data.
- Bytes per transaction = len+1; counter sized to reach MAX_BYTES with no wrap.

Test Plan:
- NOP: cmd 8'hFF, len 0, engine model returns 8'h0E -> one o_TX_DV with 8'hFF, o_Status=8'h0E, one o_Done, zero o_Rd_Valid, CS low at least SETUP+HOLD clocks.
- Read register: cmd 8'h05, rd, len 1, model returns 8'h0E,8'h02 -> TX 8'h05 then 8'hFF; o_Rd_Byte=8'h02 on single o_Rd_Valid; o_Status=8'h0E.
- Write TX_ADDR: cmd 8'h30, wr, len 5, data E7 E7 E7 E7 E7, i_Wr_Valid dropped 10 clocks before byte 3 -> CS stays low through stall, exactly 6 o_TX_DV, 5 o_Wr_Ready pulses, one o_Done.
- Payload read: cmd 8'h61, rd, len 32 -> 33 bytes on TX, 32 o_Rd_Valid in order; repeat with i_Cmd_Len=40 -> clamped, identical 33-byte transfer.
- Reset asserted after 2nd o_TX_DV -> o_SPI_CS_n=1 within same clock, no o_Done; after release o_Cmd_Ready=1 next clock and new NOP completes normally.
- Back-to-back: i_Cmd_Valid held high across two NOPs -> CS high for >= CS_IDLE_CLKS (4) clocks between transactions, two o_Done pulses.
